// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scanner
//  Description : Time-multiplexed scan controller for a DIGITS-wide
//                common-anode 7-segment display. Holds a shadow display value,
//                drives one nibble per slot to a downstream hex decoder and
//                one active-low anode per slot, with a dead-time gap at the
//                start of each slot. New values arrive by valid/ready and are
//                applied only at frame boundaries.
//  Options     : define SEVEN_SEG_LZB_EN for leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scanner #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int DEAD     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [3:0]            digit_o,
    output logic [DIGITS-1:0]     anode_n,
    output logic                  frame_tick
);

    localparam int c_SLOT_W = $clog2(PRESCALE);
    localparam int c_IDX_W  = $clog2(DIGITS);

    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(PRESCALE - 1);
    localparam logic [c_SLOT_W-1:0] c_DEAD      = c_SLOT_W'(DEAD);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(DIGITS - 1);

    // Scan state encoding: BLANK during dead time, SHOW for the rest of a slot
    localparam logic [0:0] c_BLANK = 1'b0;
    localparam logic [0:0] c_SHOW  = 1'b1;

    logic [c_SLOT_W-1:0]  r_slot;
    logic [c_IDX_W-1:0]   r_idx;
    logic [4*DIGITS-1:0]  r_shadow;
    logic [4*DIGITS-1:0]  r_pend_val;
    logic                 r_pending;

    logic                 w_wrap;
    logic                 w_boundary;
    logic                 w_accept;
    logic                 w_xfer;
    logic [c_SLOT_W-1:0]  w_slot_nxt;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic [4*DIGITS-1:0]  w_shadow_nxt;
    logic                 w_pending_nxt;
    logic [0:0]           w_state_nxt;
    logic [DIGITS-1:0]    w_lit;
    logic [3:0]           w_digit_nxt;
    logic [DIGITS-1:0]    w_anode_nxt;

    // Slot/digit sequencing, handshake and shadow transfer decisions
    always_comb begin
        w_wrap     = (r_slot == c_SLOT_LAST);
        w_boundary = enable && w_wrap && (r_idx == c_IDX_LAST);
        w_accept   = load_valid && load_ready;
        // Pending is sampled as it stood at the start of the cycle, so a value
        // accepted in the boundary cycle waits for the following frame.
        w_xfer     = (!enable || w_boundary) && r_pending;

        w_slot_nxt = '0;
        w_idx_nxt  = '0;
        if (enable) begin
            if (w_wrap) begin
                w_slot_nxt = '0;
                w_idx_nxt  = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                w_slot_nxt = r_slot + 1'b1;
                w_idx_nxt  = r_idx;
            end
        end

        w_shadow_nxt  = w_xfer ? r_pend_val : r_shadow;
        w_pending_nxt = w_accept ? 1'b1 : (w_xfer ? 1'b0 : r_pending);
        w_state_nxt   = (enable && (w_slot_nxt >= c_DEAD)) ? c_SHOW : c_BLANK;
    end

    // Which digits may light: leading zeros above digit 0 are suppressed
    // when blanking is built in
`ifdef SEVEN_SEG_LZB_EN
    always_comb begin
        w_lit = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (k == 0) begin
                w_lit[k] = 1'b1;
            end else if (k == DIGITS - 1) begin
                w_lit[k] = (w_shadow_nxt[4*k +: 4] != 4'h0);
            end else begin
                w_lit[k] = (w_shadow_nxt[4*k +: 4] != 4'h0) || w_lit[k+1];
            end
        end
    end
`else
    always_comb begin
        w_lit = '1;
    end
`endif

    // Output decode from the next-cycle scan position so outputs can be registered
    always_comb begin
        w_digit_nxt = 4'h0;
        w_anode_nxt = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_idx_nxt == c_IDX_W'(k)) begin
                w_digit_nxt = w_shadow_nxt[4*k +: 4];
                if ((w_state_nxt == c_SHOW) && w_lit[k]) begin
                    w_anode_nxt[k] = 1'b0;
                end
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_slot     <= '0;
            r_idx      <= '0;
            r_shadow   <= '0;
            r_pend_val <= '0;
            r_pending  <= 1'b0;
            anode_n    <= '1;
            digit_o    <= 4'h0;
            frame_tick <= 1'b0;
            load_ready <= 1'b0;
        end else begin
            r_slot     <= w_slot_nxt;
            r_idx      <= w_idx_nxt;
            r_shadow   <= w_shadow_nxt;
            r_pending  <= w_pending_nxt;
            if (w_accept) begin
                r_pend_val <= load_value;
            end
            anode_n    <= w_anode_nxt;
            digit_o    <= w_digit_nxt;
            frame_tick <= w_boundary;
            load_ready <= !w_pending_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scanner
//  Description : Self-checking bench for seven_seg_scanner (DIGITS=4,
//                PRESCALE=8, DEAD=2). Accepted load values go into a
//                scoreboard queue and are popped into the expected display
//                value at frame boundaries or while scanning is disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scanner;

    localparam int D = 4;
    localparam int P = 8;
    localparam int DT = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_value = 16'h0;
    logic [3:0]  digit_o;
    logic [3:0]  anode_n;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    seven_seg_scanner #(.DIGITS(D), .PRESCALE(P), .DEAD(DT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .digit_o    (digit_o),
        .anode_n    (anode_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: position in the scan counted from restart, plus a
    // scoreboard of accepted-but-not-yet-displayed values
    int          m_pos = 0;
    logic [15:0] m_sh = 16'h0;
    logic [15:0] m_q[$];
    bit          m_rdy = 1'b0;
    bit          m_ft = 1'b0;
    bit          m_en = 1'b0;
    bit          m_acc;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_pos = 0; m_sh = 16'h0; m_q.delete(); m_rdy = 1'b0; m_ft = 1'b0; m_en = 1'b0;
        end else begin
            m_acc = load_valid && m_rdy;
            if (!enable) begin
                if (m_q.size() > 0) m_sh = m_q.pop_front();
                m_pos = 0;
                m_ft = 1'b0;
            end else begin
                m_ft = ((m_pos % (P*D)) == P*D - 1);
                if (m_ft && m_q.size() > 0) m_sh = m_q.pop_front();
                m_pos++;
            end
            if (m_acc) m_q.push_back(load_value);
            m_rdy = (m_q.size() == 0);
            m_en = enable;
        end
    end

    int          e_slot, e_idx;
    bit          e_lit;
    logic [3:0]  e_an, e_dig;

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_on) begin
            e_slot = m_pos % P;
            e_idx = (m_pos / P) % D;
`ifdef SEVEN_SEG_LZB_EN
            e_lit = (e_idx == 0) || ((m_sh >> (4*e_idx)) != 16'h0);
`else
            e_lit = 1'b1;
`endif
            e_an = 4'hF;
            if (m_en && e_slot >= DT && e_lit) e_an[e_idx] = 1'b0;
            e_dig = m_sh[4*e_idx +: 4];
            checks += 4;
            if (anode_n !== e_an) begin
                errors++; $display("FAIL mon_anode t=%0t got %b exp %b", $time, anode_n, e_an);
            end
            if (digit_o !== e_dig) begin
                errors++; $display("FAIL mon_digit t=%0t got %h exp %h", $time, digit_o, e_dig);
            end
            if (frame_tick !== m_ft) begin
                errors++; $display("FAIL mon_tick t=%0t got %b exp %b", $time, frame_tick, m_ft);
            end
            if (load_ready !== m_rdy) begin
                errors++; $display("FAIL mon_ready t=%0t got %b exp %b", $time, load_ready, m_rdy);
            end
        end
    end

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; enable = 1'b1; load_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_on = 1'b1;
            checks++;
            if (anode_n !== 4'hF || digit_o !== 4'h0 || frame_tick !== 1'b0 || load_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_vals got an=%b dig=%h ft=%b rdy=%b exp 1111/0/0/0", anode_n, digit_o, frame_tick, load_ready);
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (load_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b exp 1", load_ready);
        end
        @(negedge clk);
        checks++;
        if (anode_n !== 4'b1110) begin
            errors++; $display("FAIL reset_first_anode got %b exp 1110", anode_n);
        end
    endtask

    task automatic test_load_1234;
        bit ok;
        logic [15:0] v = 16'h1234;
        logic [3:0] ea;
        load_valid = 1'b1; load_value = v;
        @(negedge clk);
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin
            errors++; $display("FAIL load_ready_fall got %b exp 0", load_ready);
        end
        wait_tick(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL load_tick got none exp frame_tick");
        end
        for (int j = 0; j < P*D; j++) begin
            ea = 4'hF;
            if ((j % P) >= DT) ea[j / P] = 1'b0;
            checks++;
            if (anode_n !== ea || digit_o !== v[4*(j/P) +: 4]) begin
                errors++;
                $display("FAIL load_frame j=%0d got an=%b dig=%h exp an=%b dig=%h", j, anode_n, digit_o, ea, v[4*(j/P) +: 4]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        bit seen = 1'b0;
        load_valid = 1'b1; load_value = 16'hAAAA;
        @(negedge clk);
        load_value = 16'h5555;
        for (int i = 0; i < 100; i++) begin
            if (frame_tick === 1'b1) begin
                seen = 1'b1;
                break;
            end
            checks++;
            if (load_ready !== 1'b0) begin
                errors++; $display("FAIL b2b_hold_ready i=%0d got %b exp 0", i, load_ready);
            end
            @(negedge clk);
        end
        checks++;
        if (!seen || load_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_boundary got tick=%b rdy=%b exp 1/1", seen, load_ready);
        end
        for (int j = 0; j < P*D; j++) begin
            checks++;
            if (digit_o !== 4'hA) begin
                errors++; $display("FAIL b2b_aaaa j=%0d got %h exp a", j, digit_o);
            end
            @(negedge clk);
            if (j == 0) begin
                load_valid = 1'b0;
                checks++;
                if (load_ready !== 1'b0) begin
                    errors++; $display("FAIL b2b_accept2 got %b exp 0", load_ready);
                end
            end
        end
        checks++;
        if (frame_tick !== 1'b1 || digit_o !== 4'h5) begin
            errors++; $display("FAIL b2b_5555 got tick=%b dig=%h exp 1/5", frame_tick, digit_o);
        end
    endtask

    task automatic test_disable;
        load_valid = 1'b1; load_value = 16'hBEEF;
        @(negedge clk);
        load_valid = 1'b0;
        repeat (19) @(negedge clk);
        checks++;
        if (anode_n !== 4'b1011 || digit_o !== 4'h5) begin
            errors++; $display("FAIL dis_pre got an=%b dig=%h exp 1011/5", anode_n, digit_o);
        end
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (anode_n !== 4'hF || digit_o !== 4'hF || frame_tick !== 1'b0) begin
                errors++; $display("FAIL dis_dark i=%0d got an=%b dig=%h ft=%b exp 1111/f/0", i, anode_n, digit_o, frame_tick);
            end
        end
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (anode_n !== 4'hF) begin
            errors++; $display("FAIL dis_restart_dead got %b exp 1111", anode_n);
        end
        @(negedge clk);
        checks++;
        if (anode_n !== 4'b1110 || digit_o !== 4'hF) begin
            errors++; $display("FAIL dis_restart_show got an=%b dig=%h exp 1110/f", anode_n, digit_o);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        wait_tick(ok);
        repeat (3*P + 3) @(negedge clk);
        checks++;
        if (!ok || anode_n !== 4'b0111) begin
            errors++; $display("FAIL rmid_pos got tick=%b an=%b exp 1/0111", ok, anode_n);
        end
        load_valid = 1'b1; load_value = 16'h9876;
        @(negedge clk);
        load_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (anode_n !== 4'hF || digit_o !== 4'h0 || load_ready !== 1'b0) begin
            errors++; $display("FAIL rmid_reset got an=%b dig=%h rdy=%b exp 1111/0/0", anode_n, digit_o, load_ready);
        end
        @(negedge clk);
        checks++;
        if (load_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_ready got %b exp 1", load_ready);
        end
        @(negedge clk);
        checks++;
        if (anode_n !== 4'b1110 || digit_o !== 4'h0) begin
            errors++; $display("FAIL rmid_restart got an=%b dig=%h exp 1110/0", anode_n, digit_o);
        end
        wait_tick(ok);
        checks++;
        if (!ok || digit_o !== 4'h0) begin
            errors++; $display("FAIL rmid_dropped got tick=%b dig=%h exp 1/0", ok, digit_o);
        end
    endtask

    task automatic test_lzb;
        bit ok;
        bit lit;
        logic [15:0] vals [2] = '{16'h0042, 16'h0000};
        logic [15:0] v;
        logic [3:0] ea;
        for (int n = 0; n < 2; n++) begin
            v = vals[n];
            load_valid = 1'b1; load_value = v;
            @(negedge clk);
            load_valid = 1'b0;
            wait_tick(ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL lzb_tick n=%0d got none exp frame_tick", n);
            end
            for (int j = 0; j < P*D; j++) begin
`ifdef SEVEN_SEG_LZB_EN
                lit = (n == 0) ? ((j / P) < 2) : ((j / P) == 0);
`else
                lit = 1'b1;
`endif
                ea = 4'hF;
                if ((j % P) >= DT && lit) ea[j / P] = 1'b0;
                checks++;
                if (anode_n !== ea || digit_o !== v[4*(j/P) +: 4]) begin
                    errors++;
                    $display("FAIL lzb_frame n=%0d j=%0d got an=%b dig=%h exp an=%b dig=%h", n, j, anode_n, digit_o, ea, v[4*(j/P) +: 4]);
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_1234();
        test_back_to_back();
        test_disable();
        test_reset_mid();
        test_lzb();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
